// File: rtl/mem_port_sched.sv
// mem_port_sched: arbitrates the shared memory port between fetch and data, one access at a time
// Data wins over fetch, hung accesses are aborted after TO_CYC busy cycles, and pipeline stalls are produced.
module mem_port_sched #(
    parameter int AW     = 32,
    parameter int TO_CYC = 64,
    parameter int TOW    = 7
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic [31:0]   if_rdata,
    output logic          if_valid,
    input  logic          d_req,
    input  logic          d_wen,
    input  logic [AW-1:0] d_addr,
    input  logic [31:0]   d_wdata,
    input  logic [3:0]    d_be,
    output logic [31:0]   d_rdata,
    output logic          d_valid,
    output logic          mem_csn,
    output logic          mem_wen,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    output logic [3:0]    mem_be,
    input  logic [31:0]   mem_rdata,
    input  logic          mem_ack,
    output logic          stall_f,
    output logic          stall_all,
    output logic          timeout_err
);
    typedef enum logic [2:0] {IDLE, IBUSY, DBUSY, IDONE, DDONE} state_t;

    state_t         state, state_nxt;
    logic [TOW-1:0] cnt;
    logic           wen_q, busy, timed_out, finish;

    assign busy      = (state == IBUSY) || (state == DBUSY);
    assign timed_out = busy && !mem_ack && (cnt == TOW'(TO_CYC - 1));
    assign finish    = busy && (mem_ack || timed_out);
    assign mem_csn   = !busy;
    assign mem_wen   = busy ? wen_q : 1'b1;
    assign if_valid  = state == IDONE;
    assign d_valid   = state == DDONE;
    assign stall_all = rst_n && d_req && (state != DDONE);
    assign stall_f   = (rst_n && if_req && (state != IDONE)) || stall_all;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = d_req ? DBUSY : (if_req ? IBUSY : IDLE);
            IBUSY:   state_nxt = finish ? IDONE : IBUSY;
            DBUSY:   state_nxt = finish ? DDONE : DBUSY;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt         <= '0;
            wen_q       <= 1'b1;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_be      <= '0;
            if_rdata    <= '0;
            d_rdata     <= '0;
            timeout_err <= 1'b0;
        end else begin
            cnt <= (busy && !finish) ? cnt + 1'b1 : '0;
            if (state == IDLE && d_req) begin
                mem_addr  <= d_addr;
                mem_wdata <= d_wdata;
                mem_be    <= d_wen ? 4'hF : d_be;
                wen_q     <= d_wen;
            end else if (state == IDLE && if_req) begin
                mem_addr <= if_addr;
                mem_be   <= 4'hF;
                wen_q    <= 1'b1;
            end
            if (state == IBUSY && finish)
                if_rdata <= mem_ack ? mem_rdata : '0;
            // an aborted store also clears D_RDATA so no stale load data is presented with the forced completion
            if (state == DBUSY && (timed_out || (mem_ack && wen_q)))
                d_rdata <= mem_ack ? mem_rdata : '0;
            if (timed_out)
                timeout_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_mem_port_sched.sv
// tb_mem_port_sched: randomized transaction bench for mem_port_sched
// Expected timing is derived per transaction from ack delay arithmetic; a responder process plays the memory.
module tb_mem_port_sched;
    localparam int AW = 32;
    localparam int TO = 8;

    logic          clk = 1'b0, rst_n = 1'b0;
    logic          if_req = 1'b0, d_req = 1'b0, d_wen = 1'b1, mem_ack = 1'b0;
    logic [AW-1:0] if_addr = '0, d_addr = '0;
    logic [31:0]   d_wdata = '0, mem_rdata = '0;
    logic [3:0]    d_be = '0;
    logic [31:0]   if_rdata, d_rdata, mem_wdata;
    logic [AW-1:0] mem_addr;
    logic [3:0]    mem_be;
    logic          if_valid, d_valid, mem_csn, mem_wen, stall_f, stall_all, timeout_err;

    mem_port_sched #(.AW(AW), .TO_CYC(TO), .TOW(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
        .d_req(d_req), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_rdata(d_rdata), .d_valid(d_valid),
        .mem_csn(mem_csn), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .stall_f(stall_f), .stall_all(stall_all), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rd;
        logic [3:0]  be;
        logic        wen;
        int          dly;
    } acc_t;

    acc_t        exp_q[$];
    acc_t        cur;
    int          vecs = 0, errs = 0, bcnt = 0, accesses = 0;
    logic        err_exp = 1'b0;
    logic [31:0] d_rd_exp = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // memory model: acks after cur.dly extra cycles, sprays random ACK/RDATA while idle
    always @(negedge clk) begin
        if (!mem_csn) begin
            bcnt++;
            if (bcnt == 1) begin
                accesses++;
                check("access_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    cur = exp_q.pop_front();
                    check("mem_addr", mem_addr, cur.addr);
                    check("mem_wen", mem_wen, cur.wen);
                    check("mem_be", mem_be, cur.be);
                    if (!cur.wen) check("mem_wdata", mem_wdata, cur.wdata);
                end
            end
            mem_ack   = (bcnt == cur.dly + 1);
            mem_rdata = mem_ack ? cur.rd : $urandom;
        end else begin
            bcnt      = 0;
            mem_ack   = ($urandom_range(0, 3) == 0);
            mem_rdata = $urandom;
        end
    end

    task automatic run_txn(input bit do_f, input bit do_d, input logic wen, input int df, input int dd);
        logic [31:0] fa, da, wd, rf, rdd;
        logic [3:0]  be;
        int          bf, bd, kf, kd, acc0;
        acc_t        a;
        fa = $urandom; da = $urandom; wd = $urandom; rf = $urandom; rdd = $urandom; be = 4'($urandom);
        bd = (dd + 1 < TO) ? dd + 1 : TO;
        bf = (df + 1 < TO) ? df + 1 : TO;
        kd = do_d ? 1 + bd : -1;
        kf = do_f ? (do_d ? kd + 2 + bf : 1 + bf) : -1;
        if (do_d) begin
            a.addr = da; a.wdata = wd; a.rd = rdd; a.be = wen ? 4'hF : be; a.wen = wen; a.dly = dd;
            exp_q.push_back(a);
        end
        if (do_f) begin
            a.addr = fa; a.wdata = '0; a.rd = rf; a.be = 4'hF; a.wen = 1'b1; a.dly = df;
            exp_q.push_back(a);
        end
        acc0 = accesses;
        if_req = do_f; if_addr = fa;
        d_req = do_d; d_wen = wen; d_addr = da; d_wdata = wd; d_be = be;
        for (int k = 1; k <= 60 && (if_req || d_req); k++) begin
            @(posedge clk); #1;
            check("d_valid", d_valid, k == kd);
            check("if_valid", if_valid, k == kf);
            check("stall_all", stall_all, d_req && k != kd);
            check("stall_f", stall_f, (if_req && k != kf) || (d_req && k != kd));
            if (k == kd) begin
                if (dd >= TO) err_exp = 1'b1;
                if (wen) d_rd_exp = (dd >= TO) ? 32'h0 : rdd;
                check("d_rdata", d_rdata, d_rd_exp);
                check("timeout_err", timeout_err, err_exp);
                d_req = 1'b0;
            end
            if (k == kf) begin
                if (df >= TO) err_exp = 1'b1;
                check("if_rdata", if_rdata, (df >= TO) ? 32'h0 : rf);
                check("timeout_err", timeout_err, err_exp);
                if_req = 1'b0;
            end
        end
        check("txn_complete", if_req || d_req, 0);
        if_req = 1'b0; d_req = 1'b0;
        check("access_count", accesses - acc0, int'(do_f) + int'(do_d));
        @(posedge clk); #1;
        check("idle_csn", mem_csn, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        if_req = 1'b1; d_req = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_csn", mem_csn, 1);
        check("rst_wen", mem_wen, 1);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_be", mem_be, 0);
        check("rst_if_rdata", if_rdata, 0);
        check("rst_d_rdata", d_rdata, 0);
        check("rst_if_valid", if_valid, 0);
        check("rst_d_valid", d_valid, 0);
        check("rst_err", timeout_err, 0);
        check("rst_stall_all", stall_all, 0);
        check("rst_stall_f", stall_f, 0);
        if_req = 1'b0; d_req = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_txn(1, 0, 1, 0, 0);
        run_txn(1, 1, 1, 0, 0);
        run_txn(0, 1, 0, 0, 2);
        run_txn(1, 0, 1, 5, 0);
        run_txn(0, 1, 1, 0, 7);
        run_txn(1, 0, 1, 8, 0);
        run_txn(0, 1, 1, 0, 11);
        run_txn(1, 1, 1, 2, 3);

        a_reset_mid_access();

        for (int i = 0; i < 60; i++) begin
            int   kind;
            logic wen;
            kind = $urandom_range(0, 2);
            wen  = 1'($urandom);
            run_txn(kind != 1, kind != 0, wen, $urandom_range(0, 10),
                    wen ? $urandom_range(0, 10) : $urandom_range(0, 7));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

    task automatic a_reset_mid_access();
        acc_t a;
        a.addr = 32'h200; a.wdata = '0; a.rd = 32'hCAFE; a.be = 4'hF; a.wen = 1'b1; a.dly = 20;
        exp_q.push_back(a);
        d_req = 1'b1; d_wen = 1'b1; d_addr = 32'h200;
        repeat (3) @(posedge clk);
        #1;
        check("pre_rst_csn", mem_csn, 0);
        rst_n = 1'b0;
        #1;
        check("mid_rst_csn", mem_csn, 1);
        check("mid_rst_stall_all", stall_all, 0);
        check("mid_rst_stall_f", stall_f, 0);
        check("mid_rst_err", timeout_err, 0);
        err_exp  = 1'b0;
        d_rd_exp = '0;
        d_req    = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_d_rdata", d_rdata, 0);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            check("post_rst_d_valid", d_valid, 0);
            check("post_rst_csn", mem_csn, 1);
        end
        run_txn(0, 1, 1, 0, 1);
    endtask
endmodule
